// File: rtl/imm_fetch_pkg.sv
// imm_fetch_pkg: state encoding and opcode field positions shared by the fetch block.
package imm_fetch_pkg;
    typedef enum logic [1:0] {FETCH_OP, FETCH_IMM, HOLD} state_t;
    localparam int OP_HAS_IMM = 0;
    localparam int OP_SIGNED  = 1;
endpackage

// File: rtl/imm_fetch_fetch_ptr.sv
// fetch_ptr: 16-bit fetch pointer with load and wrapping increment.
module fetch_ptr (
    input  logic        clk,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_inc,
    output logic [15:0] o_ptr
);
    logic [15:0] r_ptr;
    always_ff @(posedge clk)
        r_ptr <= i_load ? i_load_val : r_ptr + (i_inc ? 16'd1 : 16'd0);
    assign o_ptr = r_ptr;
endmodule

// File: rtl/imm_fetch.sv
// imm_fetch: fetches an opcode byte plus an optional immediate byte and holds them until taken.
module imm_fetch
    import imm_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    input  logic        stall,
    input  logic        branch,
    input  logic [15:0] branch_target,
    output logic        valid,
    output logic [7:0]  op,
    output logic [7:0]  imm,
    output logic        s,
    output logic [15:0] pc
);
    state_t      r_state;
    logic [7:0]  r_op, r_imm;
    logic        r_s;
    logic [15:0] r_pc;
    logic [15:0] w_ptr;
    logic        w_take;

    // reset gating keeps the request low for every cycle reset is held
    assign mem_req  = !reset && r_state != HOLD;
    assign w_take   = mem_req && mem_ack && !branch;
    assign mem_addr = w_ptr;
    assign valid    = r_state == HOLD;
    assign op       = r_op;
    assign imm      = r_imm;
    assign s        = r_s;
    assign pc       = r_pc;

    fetch_ptr u_ptr (
        .clk        (clk),
        .i_load     (reset || branch),
        .i_load_val (reset ? RESET_PC : branch_target),
        .i_inc      (w_take),
        .o_ptr      (w_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH_OP;
            r_op    <= 8'h00;
            r_imm   <= 8'h00;
            r_s     <= 1'b0;
            r_pc    <= RESET_PC;
        end else if (branch) begin
            r_state <= FETCH_OP;
        end else begin
            case (r_state)
                FETCH_OP: if (mem_ack) begin
                    r_op  <= mem_data;
                    r_pc  <= w_ptr;
                    r_s   <= mem_data[OP_HAS_IMM] & mem_data[OP_SIGNED];
                    if (mem_data[OP_HAS_IMM]) r_state <= FETCH_IMM;
                    else begin
                        r_imm   <= 8'h00;
                        r_state <= HOLD;
                    end
                end
                FETCH_IMM: if (mem_ack) begin
                    r_imm   <= mem_data;
                    r_state <= HOLD;
                end
                HOLD: if (!stall) r_state <= FETCH_OP;
                default: r_state <= FETCH_OP;
            endcase
        end
    end
endmodule

// File: doc/imm_fetch.md
IMM_FETCH -- requirements
Module: imm_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, byte address fetched first after reset.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_req  output  1  instruction-memory read request.
REQ-005 mem_addr  output  16  byte address of current request.
REQ-006 mem_ack  input  1  mem_data valid this cycle for current request.
REQ-007 mem_data  input  8  instruction byte.
REQ-008 stall  input  1  downstream (extender/execute) cannot accept this cycle.
REQ-009 branch  input  1  redirect fetch to branch_target.
REQ-010 branch_target  input  16  redirect address.
REQ-011 valid  output  1  op/imm/s/pc hold a complete instruction.
REQ-012 op  output  8  latched opcode byte.
REQ-013 imm  output  8  latched immediate byte; drives the sign/zero extender input.
REQ-014 s  output  1  extension select for the extender: 1 = sign-extend, 0 = zero-extend.
REQ-015 pc  output  16  address of the opcode byte of the held instruction.

Function
REQ-016 States: FETCH_OP, FETCH_IMM, HOLD.
REQ-017 FETCH_OP: mem_req=1, mem_addr=fetch pointer; on mem_ack latch op=mem_data, pc=fetch pointer, pointer+1; go to FETCH_IMM if mem_data[0]=1, else imm=8'h00 and go to HOLD.
REQ-018 FETCH_IMM: mem_req=1, mem_addr=fetch pointer; on mem_ack latch imm=mem_data, pointer+1, go to HOLD.
REQ-019 s SHALL be latched from opcode bit 1 when op is latched; s=0 for opcodes with bit 0 = 0.
REQ-020 HOLD: valid=1, mem_req=0; op/imm/s/pc stable while stall=1.
REQ-021 Transfer occurs when valid=1 and stall=0; next cycle state=FETCH_OP, valid=0.
REQ-022 Without mem_ack the FSM SHALL remain in its state with mem_req and mem_addr unchanged; no timeout.
REQ-023 Fetch pointer SHALL wrap 16'hFFFF -> 16'h0000; an immediate at 16'h0000 following an opcode at 16'hFFFF is legal.
REQ-024 branch=1 in any state: next cycle pointer=branch_target, state=FETCH_OP, valid=0; any mem_ack in that cycle is discarded.
REQ-025 branch has priority over mem_ack, stall and transfer in the same cycle.
REQ-026 Minimum throughput: 2 cycles per no-immediate instruction, 3 per immediate instruction, with mem_ack=1 and stall=0 continuously.
REQ-027 Outputs SHALL come from registers or the state decode only; no combinational path from mem_data to op/imm/s.

Reset
REQ-028 reset=1 at a rising edge: state=FETCH_OP, pointer=RESET_PC, valid=0, op=8'h00, imm=8'h00, s=0, pc=RESET_PC.
REQ-029 During reset mem_req SHALL be 0; first request issues the cycle after reset deasserts.
REQ-030 Reset mid-fetch or in HOLD SHALL abandon the instruction; a mem_ack during reset is ignored.

Structure
REQ-031 Shared package holds state encoding and opcode field positions (OP_HAS_IMM=0, OP_SIGNED=1).
REQ-032 One sub-module, fetch_ptr: 16-bit pointer with load (reset/branch) and increment, wrapping.
REQ-033 Total RTL 120-400 lines; no memories inside the block.

Verification
REQ-034 Reset, mem_ack=1 always, mem bytes 8'h00 at 0 -> valid at cycle 2, op=00, imm=00, s=0, pc=0000.
REQ-035 Bytes 8'h03,8'hF7 at 0,1 -> op=03, imm=F7, s=1; extender output FFF7; next opcode fetched at 0002.
REQ-036 Bytes 8'h01,8'h09 with stall=1 for 4 cycles -> valid, op=01, imm=09, s=0 held 4 cycles, mem_req=0 throughout.
REQ-037 RESET_PC=16'hFFFF, bytes 8'h03 at FFFF, 8'h80 at 0000 -> pc=FFFF, imm=80, s=1, next fetch at 0001.
REQ-038 branch=1, branch_target=16'h1234 in same cycle as mem_ack in FETCH_IMM -> data discarded, valid=0, next mem_addr=1234.
REQ-039 reset asserted in HOLD with stall=1 -> next cycle valid=0, mem_req=0; after release mem_addr=RESET_PC.
